// File: rtl/spectrum_capture.sv
// spectrum_capture: armed single-frame spectrum capture into RAM with live peak-magnitude tracking
module spectrum_capture #(
  parameter int DW = 16,
  parameter int N = 256,
  localparam int AW = $clog2(N)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [2*DW-1:0] data_i,
  input  logic            sob_i,
  input  logic            eob_i,
  input  logic            valid_i,
  input  logic            arm_i,
  input  logic [AW-1:0]   rd_addr_i,
  output logic [2*DW-1:0] rd_data_o,
  output logic            ready_o,
  output logic            busy_o,
  output logic            err_o,
  output logic [AW-1:0]   peak_bin_o,
  output logic [DW:0]     peak_mag_o
);
  typedef enum logic [1:0] {IDLE, WAIT_SOB, CAPTURE, DONE} state_t;
  state_t state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d, peak_bin_q, peak_bin_d, waddr;
  logic [DW:0] peak_mag_q, peak_mag_d, mag;
  logic ready_q, ready_d, err_q, err_d, we;
  logic [DW-1:0] re, im, are, aim;
  logic [2*DW-1:0] mem [N];
  logic [2*DW-1:0] rd_data_q;
  assign re = data_i[DW-1:0];
  assign im = data_i[2*DW-1:DW];
  // unsigned DW-bit abs holds 2^(DW-1) exactly, so the sum never wraps
  assign are = re[DW-1] ? ~re + 1'b1 : re;
  assign aim = im[DW-1] ? ~im + 1'b1 : im;
  assign mag = {1'b0, are} + {1'b0, aim};
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    ready_d = ready_q;
    err_d = err_q;
    peak_bin_d = peak_bin_q;
    peak_mag_d = peak_mag_q;
    we = 1'b0;
    waddr = cnt_q;
    case (state_q)
      IDLE, DONE: if (arm_i) begin
        state_d = WAIT_SOB;
        ready_d = 1'b0;
        err_d = 1'b0;
        peak_bin_d = '0;
        peak_mag_d = '0;
      end
      WAIT_SOB: if (valid_i && sob_i) begin
        we = 1'b1;
        waddr = '0;
        peak_bin_d = '0;
        peak_mag_d = mag;
        err_d = err_q | eob_i;
        state_d = eob_i ? WAIT_SOB : CAPTURE;
        cnt_d = eob_i ? '0 : AW'(1);
      end
      CAPTURE: if (valid_i) begin
        we = 1'b1;
        if (sob_i) begin
          waddr = '0;
          err_d = 1'b1;
          cnt_d = AW'(1);
          peak_bin_d = '0;
          peak_mag_d = mag;
        end else begin
          if (mag > peak_mag_q) begin
            peak_bin_d = cnt_q;
            peak_mag_d = mag;
          end
          if (cnt_q == AW'(N - 1) && eob_i) begin
            state_d = DONE;
            ready_d = 1'b1;
            cnt_d = '0;
          end else if (cnt_q == AW'(N - 1) || eob_i) begin
            state_d = WAIT_SOB;
            err_d = 1'b1;
            cnt_d = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q <= '0;
      ready_q <= 1'b0;
      err_q <= 1'b0;
      peak_bin_q <= '0;
      peak_mag_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      ready_q <= ready_d;
      err_q <= err_d;
      peak_bin_q <= peak_bin_d;
      peak_mag_q <= peak_mag_d;
    end
  end
  always_ff @(posedge clk_i) begin
    if (we) mem[waddr] <= data_i;
    rd_data_q <= mem[rd_addr_i];
  end
  assign rd_data_o = rd_data_q;
  assign ready_o = ready_q;
  assign err_o = err_q;
  assign busy_o = state_q == WAIT_SOB || state_q == CAPTURE;
  assign peak_bin_o = peak_bin_q;
  assign peak_mag_o = peak_mag_q;
endmodule

// File: tb/tb_spectrum_capture.sv
// tb_spectrum_capture: directed checks of spectrum_capture with N=8, DW=16
module tb_spectrum_capture;
  localparam int DW = 16;
  localparam int N = 8;
  localparam int AW = 3;
  logic clk = 1'b0;
  logic rst_i = 1'b0;
  logic [2*DW-1:0] data_i = '0;
  logic sob_i = 1'b0, eob_i = 1'b0, valid_i = 1'b0, arm_i = 1'b0;
  logic [AW-1:0] rd_addr_i = '0;
  logic [2*DW-1:0] rd_data_o;
  logic ready_o, busy_o, err_o;
  logic [AW-1:0] peak_bin_o;
  logic [DW:0] peak_mag_o;
  int vecs = 0;
  int errs = 0;
  spectrum_capture #(.DW(DW), .N(N)) dut (
    .clk_i(clk), .rst_i(rst_i), .data_i(data_i), .sob_i(sob_i), .eob_i(eob_i),
    .valid_i(valid_i), .arm_i(arm_i), .rd_addr_i(rd_addr_i), .rd_data_o(rd_data_o),
    .ready_o(ready_o), .busy_o(busy_o), .err_o(err_o),
    .peak_bin_o(peak_bin_o), .peak_mag_o(peak_mag_o)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic send(input int re, input int im, input logic s, input logic e);
    data_i = {im[15:0], re[15:0]};
    sob_i = s;
    eob_i = e;
    valid_i = 1'b1;
    tick();
    valid_i = 1'b0;
    sob_i = 1'b0;
    eob_i = 1'b0;
  endtask
  task automatic arm();
    arm_i = 1'b1;
    tick();
    arm_i = 1'b0;
  endtask
  task automatic rd(input int a, input string tag, input logic [31:0] exp);
    rd_addr_i = a[AW-1:0];
    tick();
    chk(tag, {32'd0, rd_data_o}, {32'd0, exp});
  endtask
  initial begin
    #1;
    rst_i = 1'b1;
    tick();
    tick();
    rst_i = 1'b0;
    chk("rst_ready", ready_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_pbin", peak_bin_o, 0);
    chk("rst_pmag", peak_mag_o, 0);
    // clean frame
    arm();
    chk("arm_busy", busy_o, 1);
    for (int k = 0; k < 8; k++) send(k, -k, k == 0, k == 7);
    chk("clean_ready", ready_o, 1);
    chk("clean_err", err_o, 0);
    chk("clean_busy", busy_o, 0);
    chk("clean_pbin", peak_bin_o, 7);
    chk("clean_pmag", peak_mag_o, 14);
    rd(3, "clean_rd3", 32'hFFFD_0003);
    rd(0, "clean_rd0", 32'h0000_0000);
    rd(7, "clean_rd7", 32'hFFF9_0007);
    // gapped frame after wiping bin 3 with a different frame
    arm();
    chk("rearm_ready", ready_o, 0);
    for (int k = 0; k < 8; k++) send(9, 9, k == 0, k == 7);
    arm();
    for (int k = 0; k < 8; k++) begin
      send(k, -k, k == 0, k == 7);
      if (k < 7) tick();
    end
    chk("gap_ready", ready_o, 1);
    chk("gap_pbin", peak_bin_o, 7);
    chk("gap_pmag", peak_mag_o, 14);
    rd(3, "gap_rd3", 32'hFFFD_0003);
    rd(5, "gap_rd5", 32'hFFFB_0005);
    // early eob then clean frame
    arm();
    for (int k = 0; k < 5; k++) send(k, -k, k == 0, k == 4);
    chk("early_err", err_o, 1);
    chk("early_busy", busy_o, 1);
    chk("early_ready", ready_o, 0);
    for (int k = 0; k < 8; k++) send(k, -k, k == 0, k == 7);
    chk("early2_err", err_o, 1);
    chk("early2_ready", ready_o, 1);
    chk("early2_pmag", peak_mag_o, 14);
    // mid-frame sob: partial bins are large, restart must drop them from the peak
    arm();
    chk("arm_clr_err", err_o, 0);
    for (int k = 0; k < 5; k++) send(50, 50, k == 0, 1'b0);
    for (int k = 0; k < 8; k++) send(2 * k, 1, k == 0, k == 7);
    chk("midsob_err", err_o, 1);
    chk("midsob_ready", ready_o, 1);
    chk("midsob_pbin", peak_bin_o, 7);
    chk("midsob_pmag", peak_mag_o, 15);
    rd(0, "midsob_rd0", 32'h0001_0000);
    rd(4, "midsob_rd4", 32'h0001_0008);
    // magnitude extreme
    arm();
    for (int k = 0; k < 8; k++)
      if (k == 3) send(-32768, -32768, 1'b0, 1'b0);
      else send(0, 0, k == 0, k == 7);
    chk("ext_ready", ready_o, 1);
    chk("ext_pmag", peak_mag_o, 65536);
    chk("ext_pbin", peak_bin_o, 3);
    rd(3, "ext_rd3", 32'h8000_8000);
    // tie: equal peaks at bins 2 and 6
    arm();
    for (int k = 0; k < 8; k++)
      if (k == 2 || k == 6) send(5, -7, 1'b0, k == 7);
      else send(0, 0, k == 0, k == 7);
    chk("tie_pbin", peak_bin_o, 2);
    chk("tie_pmag", peak_mag_o, 12);
    // sob+eob together while waiting is a framing error
    arm();
    send(1, 1, 1'b1, 1'b1);
    chk("sobeob_err", err_o, 1);
    chk("sobeob_busy", busy_o, 1);
    // arm ignored mid-capture: err must survive it
    send(0, 0, 1'b1, 1'b0);
    arm();
    chk("armig_err", err_o, 1);
    // reset mid-capture, rst_i beats arm_i
    for (int k = 1; k < 3; k++) send(k, 0, 1'b0, 1'b0);
    rst_i = 1'b1;
    arm_i = 1'b1;
    send(3, 0, 1'b0, 1'b0);
    rst_i = 1'b0;
    arm_i = 1'b0;
    chk("rstmid_busy", busy_o, 0);
    chk("rstmid_err", err_o, 0);
    chk("rstmid_ready", ready_o, 0);
    for (int k = 0; k < 8; k++) send(k, k, k == 0, k == 7);
    chk("noarm_ready", ready_o, 0);
    chk("noarm_busy", busy_o, 0);
    chk("noarm_pmag", peak_mag_o, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/spectrum_capture.md
SPECTRUM_CAPTURE -- requirements
Module: spectrum_capture

Interface
REQ-001 SHALL have parameter DW, default 16, meaning bit width of each of the RE and IM parts.
REQ-002 SHALL have parameter N, default 256, meaning bins per frame; N must be a power of two and at least 4.
REQ-003 SHALL have localparam AW = $clog2(N).
REQ-004 SHALL have port clk_i, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 SHALL have port rst_i, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have port data_i, input, 2*DW bits: bin sample packed {IM, RE}, each part signed two's complement.
REQ-007 SHALL have ports sob_i, eob_i and valid_i, inputs, 1 bit each: start of block, end of block and sample valid; sob_i and eob_i are qualified by valid_i.
REQ-008 SHALL have port arm_i, input, 1 bit: a one-cycle pulse that requests capture of the next complete frame.
REQ-009 SHALL have port rd_addr_i, input, AW bits: read bin index.
REQ-010 SHALL have port rd_data_o, output, 2*DW bits: captured bin at rd_addr_i, packed {IM, RE}.
REQ-011 SHALL have port ready_o, output, 1 bit: a complete frame is held and may be read.
REQ-012 SHALL have port busy_o, output, 1 bit: armed, waiting for a frame or capturing one.
REQ-013 SHALL have port err_o, output, 1 bit: sticky framing-error flag.
REQ-014 SHALL have port peak_bin_o, output, AW bits: index of the largest-magnitude bin in the captured frame.
REQ-015 SHALL have port peak_mag_o, output, DW+1 bits, unsigned: |RE|+|IM| of that bin.

Function
REQ-016 SHALL implement an FSM with states IDLE, WAIT_SOB, CAPTURE and DONE.
REQ-017 SHALL move from IDLE or DONE to WAIT_SOB on arm_i; at the same time it clears ready_o, err_o, peak_bin_o and peak_mag_o.
REQ-018 SHALL ignore arm_i while in WAIT_SOB or CAPTURE.
REQ-019 SHALL, in WAIT_SOB, ignore samples until valid_i && sob_i; that sample is written to bin 0, the bin counter is set to 1, and the FSM enters CAPTURE.
REQ-020 SHALL, in CAPTURE, write each valid_i sample to the bin given by the counter and then increment the counter; cycles with valid_i=0 write nothing and leave the counter unchanged.
REQ-021 SHALL enter DONE and set ready_o when a valid sample with eob_i=1 is written to bin N-1.
REQ-022 SHALL treat a valid sample with sob_i=1 during CAPTURE as a framing error: set err_o, restart the capture with that sample at bin 0, reset the peak tracking, and stay in CAPTURE.
REQ-023 SHALL treat a valid eob_i at any bin below N-1, or a missing eob_i at bin N-1, as a framing error: set err_o, discard the partial frame, and return to WAIT_SOB.
REQ-024 SHALL apply sob_i precedence when a valid sample has sob_i=1 and eob_i=1 together during CAPTURE.
REQ-025 SHALL, in WAIT_SOB, accept a sample with sob_i=1 and eob_i=1 together as a sob and immediately flag a framing error under REQ-023.
REQ-026 SHALL compute the magnitude of each sample as |RE|+|IM| into DW+1 bits with no overflow; the absolute value of -2^(DW-1) is 2^(DW-1).
REQ-027 SHALL update the peak only on a strictly greater magnitude, so the lowest bin index wins a tie; bin 0 always initialises the peak.
REQ-028 SHALL update peak_bin_o and peak_mag_o live during capture; they are valid for the frame only while ready_o=1.
REQ-029 SHALL store frames in an N x 2*DW simple dual-port RAM that can be inferred from the RTL.
REQ-030 SHALL register rd_data_o with a read latency of exactly 1 cycle.
REQ-031 SHALL give reads in CAPTURE or WAIT_SOB undefined data; reads in DONE return the captured frame.
REQ-032 SHALL hold ready_o and the stored contents in DONE until the next arm_i or reset.
REQ-033 SHALL drive busy_o=1 exactly in WAIT_SOB and CAPTURE.
REQ-034 SHALL pass data_i through no combinational path to any output.

Reset
REQ-035 SHALL, while rst_i=1 at a clock edge, enter IDLE and drive ready_o=0, busy_o=0, err_o=0, peak_bin_o=0, peak_mag_o=0 and the bin counter to 0.
REQ-036 SHALL not reset the RAM contents, and rd_data_o is undefined until the first read in DONE.
REQ-037 SHALL, when reset occurs mid-capture, discard the partial frame, ignore samples until the next arm_i, and give rst_i priority over arm_i.

Verification
REQ-038 SHALL cover a clean frame with N=8, DW=16: arm, then 8 valid bins with RE=k and IM=-k, sob on bin 0 and eob on bin 7 -> ready_o=1, err_o=0, reading address 3 returns {-3,3} one cycle later, peak_bin_o=7, peak_mag_o=14.
REQ-039 SHALL cover gapped input: the same frame with valid_i=0 inserted on alternate cycles -> identical RAM contents and peak to the clean frame.
REQ-040 SHALL cover an early eob: eob on bin 4, then a clean frame -> err_o=1 stays set, the second frame is captured, and ready_o=1.
REQ-041 SHALL cover a mid-frame sob: sob again at bin 5 followed by 8 bins -> err_o=1, ready_o=1, and the stored frame starts at the second sob.
REQ-042 SHALL cover the magnitude extreme: one bin {-32768,-32768} and the rest 0 -> peak_mag_o=65536 with no wrap; two equal peaks at bins 2 and 6 -> peak_bin_o=2.
REQ-043 SHALL cover reset mid-capture: rst_i at bin 3 -> busy_o=0 and state IDLE; a following frame without arm_i leaves ready_o=0.
